// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// state encodings, the iteration count, and small op-decoding helpers.
package mult_div_pkg;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_SIGN = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Bit 1 of the op code selects the divide family.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Bit 0 clear selects the signed variant (MULT, DIV).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_core.sv
// Iterative datapath for mult_div_unit: magnitude capture, one shift-add
// (multiply) or restoring-subtract (divide) step per cycle, and the
// combinational sign fix applied to the final magnitude result.
// The divider half exists only when MULT_DIV_UNIT_DIVIDE_EN is defined.
module mult_div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             signed_op,
`ifdef MULT_DIV_UNIT_DIVIDE_EN
  input  logic             div_op,
`endif
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic             neg_a_in, neg_b_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
  logic             div_q;
  logic [WIDTH:0]   rem_sh, diff;
  logic             q_bit;
`endif

  // Operand magnitudes; unsigned ops never negate.
  always_comb begin
    neg_a_in = signed_op & src_a[WIDTH-1];
    neg_b_in = signed_op & src_b[WIDTH-1];
    mag_a    = neg_a_in ? -src_a : src_a;
    mag_b    = neg_b_in ? -src_b : src_b;
  end

  // Next accumulator value for one iteration of the selected algorithm.
  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd};
    q_bit  = (rem_sh >= {1'b0, opnd});
    if (div_q) begin
      nxt_hi = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], q_bit};
    end
`endif
  end

  // Datapath registers: load magnitudes on accept, then iterate while stepping.
  always_ff @(posedge clk) begin
    if (load) begin
      neg_a  <= neg_a_in;
      neg_b  <= neg_b_in;
      acc_hi <= '0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
      div_q  <= div_op;
      acc_lo <= div_op ? mag_a : mag_b;
      opnd   <= div_op ? mag_b : mag_a;
`else
      acc_lo <= mag_b;
      opnd   <= mag_a;
`endif
    end else if (step) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

  // Sign fix: product sign is the XOR of operand signs; for divide the
  // quotient follows that XOR and the remainder follows the dividend.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    if (div_q) begin
      res_lo = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
      res_hi = neg_a ? -acc_hi : acc_hi;
    end
`endif
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit: FSM (IDLE/RUN/SIGN/DONE), 6-bit
// iteration counter and registered outputs around mult_div_core.
// Define MULT_DIV_UNIT_DIVIDE_EN to build the divider; without it DIV/DIVU
// finish in one RUN cycle with divByZero set and hi/lo untouched.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);

  state_e           state;
  logic [5:0]       cnt;
  logic             div_q;
  logic             load, step, div_fast;
  logic [WIDTH-1:0] res_hi, res_lo;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
  logic             b_zero;
`endif

  // A request is taken only when no operation is in flight.
  always_comb begin
    load = start & ((state == S_IDLE) | (state == S_DONE));
    step = (state == S_RUN);
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    div_fast = div_q & b_zero;
`else
    div_fast = div_q;
`endif
  end

  mult_div_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .load      (load),
    .step      (step),
    .signed_op (op_is_signed(op)),
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    .div_op    (op_is_div(op)),
`endif
    .src_a     (srcA),
    .src_b     (srcB),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Control FSM with counter and registered status/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      divByZero <= 1'b0;
      div_q     <= 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
      b_zero    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            cnt       <= '0;
            divByZero <= 1'b0;
            div_q     <= op_is_div(op);
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            b_zero    <= (srcB == '0);
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (div_fast) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            divByZero <= 1'b1;
            cnt       <= '0;
          end else if (cnt == 6'(ITER_COUNT - 1)) begin
            state <= S_SIGN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_SIGN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          hi    <= res_hi;
          lo    <= res_lo;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal
// expectations plus randomized operations checked every cycle against a
// cycle-count/arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0, srcB = '0;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .divByZero (divByZero)
  );

`ifdef MULT_DIV_UNIT_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic for one operation.
  task automatic compute(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output logic dz);
    longint      pa, pb, ps;
    logic [63:0] pu;
    int          sa, sb;
    rh = '0; rl = '0; dz = 1'b0;
    case (o)
      2'b00: begin
        pa = longint'(signed'(a));
        pb = longint'(signed'(b));
        ps = pa * pb;
        pu = 64'(ps);
        rh = pu[63:32]; rl = pu[31:0];
      end
      2'b01: begin
        pu = 64'(a) * 64'(b);
        rh = pu[63:32]; rl = pu[31:0];
      end
      2'b10: begin
        if (!DIV_EN || b == 32'd0) dz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'd0;
        end else begin
          sa = signed'(a); sb = signed'(b);
          rl = 32'(sa / sb); rh = 32'(sa % sb);
        end
      end
      default: begin
        if (!DIV_EN || b == 32'd0) dz = 1'b1;
        else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endtask

  // Reference model: an accepted request stays busy for a fixed number of
  // cycles, then pulses done and publishes its precomputed result.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] r_hi = '0, r_lo = '0;
  logic        r_dbz = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        if (r_dbz) m_dbz = 1'b1;
        else begin
          m_hi = r_hi; m_lo = r_lo;
        end
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        compute(op, srcA, srcB, r_hi, r_lo, r_dbz);
        m_busy = 1'b1;
        m_dbz  = 1'b0;
        m_left = r_dbz ? 1 : 33;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy",      64'(busy),      64'(m_busy));
    chk("done",      64'(done),      64'(m_done));
    chk("hi",        64'(hi),        64'(m_hi));
    chk("lo",        64'(lo),        64'(m_lo));
    chk("divByZero", 64'(divByZero), 64'(m_dbz));
  end

  // Drive a one-cycle request starting at the current negedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; k is the cycle count since the accepting edge.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) chk("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          gap, hold;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    chk("rst_dbz",  64'(divByZero), 64'd0);

    // Release reset and request in the same cycle: first edge accepts.
    rst_n = 1'b1;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, k);
    chk("multu_lat", 64'(k), 64'd34);
    chk("multu_hi",  64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo",  64'(lo), 64'h0000_0001);

    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(1, k);
    chk("mult_lat", 64'(k), 64'd34);
    chk("mult_hi",  64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo",  64'(lo), 64'hFFFF_FFFA);

    // hi=0x11, lo=0x22 as the prior result.
    issue(2'b01, 32'h8000_0001, 32'h0000_0022);
    wait_done(1, k);
    chk("prior_hi", 64'(hi), 64'h11);
    chk("prior_lo", 64'(lo), 64'h22);

    issue(2'b10, 32'h0000_0005, 32'h0000_0000);
    wait_done(1, k);
    chk("div0_lat", 64'(k), 64'd2);
    chk("div0_dbz", 64'(divByZero), 64'd1);
    chk("div0_hi",  64'(hi), 64'h11);
    chk("div0_lo",  64'(lo), 64'h22);

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(1, k);
    chk("div_lat", 64'(k), 64'd34);
    chk("div_lo",  64'(lo), 64'hFFFF_FFFD);
    chk("div_hi",  64'(hi), 64'hFFFF_FFFF);
    chk("div_dbz", 64'(divByZero), 64'd0);

    issue(2'b11, 32'd7, 32'd2);
    wait_done(1, k);
    chk("divu_lo", 64'(lo), 64'd3);
    chk("divu_hi", 64'(hi), 64'd1);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, k);
    chk("divovf_lo",  64'(lo), 64'h8000_0000);
    chk("divovf_hi",  64'(hi), 64'h0);
    chk("divovf_dbz", 64'(divByZero), 64'd0);
`else
    issue(2'b10, 32'd7, 32'd2);
    wait_done(1, k);
    chk("nodiv_lat", 64'(k), 64'd2);
    chk("nodiv_dbz", 64'(divByZero), 64'd1);
    chk("nodiv_hi",  64'(hi), 64'h11);
    chk("nodiv_lo",  64'(lo), 64'h22);
`endif

    // start held high through busy, then a new op accepted from the done cycle.
    start = 1'b1; op = 2'b01; srcA = 32'd5; srcB = 32'd6;
    @(negedge clk);
    wait_done(1, k);
    chk("hold_lat", 64'(k), 64'd34);
    chk("hold_lo",  64'(lo), 64'd30);
    op = 2'b00; srcA = 32'hFFFF_FFFF; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(1, k);
    chk("b2b_lat", 64'(k), 64'd34);
    chk("b2b_hi",  64'(hi), 64'hFFFF_FFFF);
    chk("b2b_lo",  64'(lo), 64'hFFFF_FFF9);

    // Reset during cycle 10 of RUN.
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi",   64'(hi),   64'd0);
    chk("arst_lo",   64'(lo),   64'd0);
    chk("arst_dbz",  64'(divByZero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'(done), 64'd0);
    end
    issue(2'b01, 32'd3, 32'd4);
    wait_done(1, k);
    chk("post_rst_lo", 64'(lo), 64'd12);
    chk("post_rst_hi", 64'(hi), 64'd0);

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100)) - 32'd50;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 15) == 0) begin
        ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
      end
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      hold = (ro[1] == 1'b0) ? $urandom_range(1, 6) : 1;
      start = 1'b1; op = ro; srcA = ra; srcB = rb;
      repeat (hold) @(negedge clk);
      start = 1'b0;
      wait_done(hold, k);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 srcA  input  32  multiplicand or dividend.
REQ-007 srcB  input  32  multiplier or divisor.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse on completion.
REQ-010 hi  output  32  product high word or remainder.
REQ-011 lo  output  32  product low word or quotient.
REQ-012 divByZero  output  1  valid with done; high when a divide had srcB==0.

Function
REQ-013 FSM states: IDLE, RUN, SIGN, DONE.
REQ-014 IDLE or DONE with start=1: capture op, srcA and srcB, and go to RUN; otherwise DONE->IDLE and IDLE holds.
REQ-015 start in RUN or SIGN is ignored; no queueing.
REQ-016 RUN lasts exactly 32 cycles; one shift-add bit (multiply) or one restoring-subtract bit (divide) per cycle; 6-bit iteration counter.
REQ-017 Signed ops: operands are converted to magnitude at capture; result sign is fixed in SIGN (1 cycle).
REQ-018 Latency: start sampled at edge N gives busy=1 for cycles N+1..N+33 and done=1 for cycle N+34 only.
REQ-019 busy=0 in IDLE and DONE.
REQ-020 hi and lo update only on entry to DONE, and hold until the next completion.
REQ-021 MULT/MULTU: {hi,lo} = full 64-bit signed or unsigned product.
REQ-022 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-023 Divide with srcB==0: skip RUN/SIGN, enter DONE the next cycle, divByZero=1, hi and lo unchanged.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, divByZero=0.
REQ-025 divByZero is registered and cleared at the next accepted start.

Reset
REQ-026 rst_n low immediately forces: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, divByZero=0.
REQ-027 Reset mid-operation abandons the operation; no done pulse follows reset release.
REQ-028 The first start is accepted at the first rising edge after rst_n is released.

Configuration
REQ-029 Macro MULT_DIV_UNIT_DIVIDE_EN defined: all four ops are implemented as specified.
REQ-030 Macro absent: no divider datapath; DIV/DIVU complete as in REQ-023 (1-cycle done, hi and lo unchanged, divByZero=1); multiply is unaffected.

Structure
REQ-031 Package mult_div_pkg holds: op encodings, state encoding, ITER_COUNT=32.
REQ-032 Sub-module mult_div_core holds the iterative datapath (shift register, adder/subtractor, sign fix); mult_div_unit holds the FSM, counter and output registers.

Verification
REQ-033 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at start+34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT 0xFFFFFFFE(-2)*0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-036 DIV x/0 with prior hi=0x11, lo=0x22 -> done at start+2, divByZero=1, hi and lo unchanged; without the macro, DIV 7/2 behaves the same.
REQ-037 start held high during busy -> no effect; start in the done cycle -> next op accepted back-to-back, busy in the following cycle.
REQ-038 rst_n low at cycle 10 of RUN -> all outputs 0 asynchronously; no done afterwards; a new MULTU 3*4 gives lo=12.
